// File: rtl/modular_inverse_engine.sv
// Handshaked modular inverse X = A^-1 mod p using the binary extended Euclidean
// algorithm, one reduction step per clock. Illegal or non-coprime operands raise err.
module modular_inverse_engine #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] p,
    input  logic [n-1:0] A,
    output logic [n-1:0] X,
    output logic         err,
    output logic         busy,
    output logic         result_ready
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state, state_next;
    logic [n-1:0] pr, pr_next;
    logic [n-1:0] u, u_next;
    logic [n-1:0] v, v_next;
    logic [n:0]   x1, x1_next;
    logic [n:0]   x2, x2_next;
    logic [n-1:0] x_next;
    logic         err_next;
    logic         ready_next;
    logic [n:0]   pr_ext;
    logic         operands_bad;

    // x1/x2 stay in [0, pr-1], so x + pr needs one extra bit but never overflows n+1
    assign pr_ext       = {1'b0, pr};
    assign operands_bad = !p[0] || (p < n'(3)) || (A == '0) || (A >= p);
    assign busy         = (state == RUN);

    always_comb begin
        state_next = state;
        pr_next    = pr;
        u_next     = u;
        v_next     = v;
        x1_next    = x1;
        x2_next    = x2;
        x_next     = X;
        err_next   = err;
        ready_next = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (operands_bad) begin
                        err_next   = 1'b1;
                        x_next     = '0;
                        ready_next = 1'b1;
                    end else begin
                        pr_next    = p;
                        u_next     = A;
                        v_next     = p;
                        x1_next    = (n+1)'(1);
                        x2_next    = '0;
                        err_next   = 1'b0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (u == n'(1)) begin
                    x_next     = x1[n-1:0];
                    ready_next = 1'b1;
                    state_next = IDLE;
                end else if (v == n'(1)) begin
                    x_next     = x2[n-1:0];
                    ready_next = 1'b1;
                    state_next = IDLE;
                end else if ((u == '0) || (v == '0)) begin
                    err_next   = 1'b1;
                    x_next     = '0;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end else if (!u[0]) begin
                    u_next  = u >> 1;
                    x1_next = x1[0] ? ((x1 + pr_ext) >> 1) : (x1 >> 1);
                end else if (!v[0]) begin
                    v_next  = v >> 1;
                    x2_next = x2[0] ? ((x2 + pr_ext) >> 1) : (x2 >> 1);
                end else if (u >= v) begin
                    u_next  = u - v;
                    x1_next = (x1 >= x2) ? (x1 - x2) : (x1 + pr_ext - x2);
                end else begin
                    v_next  = v - u;
                    x2_next = (x2 >= x1) ? (x2 - x1) : (x2 + pr_ext - x1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pr           <= '0;
            u            <= '0;
            v            <= '0;
            x1           <= '0;
            x2           <= '0;
            X            <= '0;
            err          <= 1'b0;
            result_ready <= 1'b0;
        end else begin
            state        <= state_next;
            pr           <= pr_next;
            u            <= u_next;
            v            <= v_next;
            x1           <= x1_next;
            x2           <= x2_next;
            X            <= x_next;
            err          <= err_next;
            result_ready <= ready_next;
        end
    end

endmodule
